cpc_io_cfg_capture: RTL and testbench
=====================================

Name: cpc_io_cfg_capture

Overview:
- Upstream stage of the 1MB RAM expansion mapper.
- Qualifies Z80 I/O write cycles to the Gate Array / RAM config port (A15 low). Rejects glitches and interrupt-acknowledge cycles.
- Latches the RAM bank-select and ROM-disable registers from the qualified cycle, with shadow-bank aliasing already applied, so the mapper only consumes stable registered values.
- Samples the DIP switches, which share the RAM high-address pins, once after reset. Controls when those pins may be driven.

Parameters:
SHADOW_BANK, 4'b0111, {adr8,data[5:3]} bank reserved for shadow RAM in 1MB mode.
MIN_LOW_CYCLES, 2, consecutive clk posedges io_wr must be seen before commit (legal range 1..7).
DIP_SETTLE_CYCLES, 4, posedges after reset release before DIPs are sampled (legal range 1..15).

Ports:
clk  in  1  CPU clock; all flops on posedge.
reset_b  in  1  asynchronous active-low reset.
iorq_b  in  1  Z80 IORQ, active low.
wr_b  in  1  Z80 WR, active low.
m1_b  in  1  Z80 M1, active low; low with iorq_b marks interrupt acknowledge.
adr15  in  1  address bit 15.
adr8  in  1  address bit 8 (selects 0x7FFF / 0x7FFE RAM in 1MB mode).
data  in  8  Z80 data bus.
dip_pins  in  4  raw DIP switch levels (bits 3,2 are shared with the RAM high-address pins).
dip_q  out  4  latched DIP setting.
dip_valid  out  1  DIPs have been sampled.
ramadrhi_oe  out  1  mapper may drive the RAM high-address pins.
ramblock_q  out  7  bank register, aliasing applied.
mode3_q  out  1  latched config data[2:0]==3'b011.
urom_disable_q  out  1  upper ROM disabled.
lrom_disable_q  out  1  lower ROM disabled.
ram_stb  out  1  one-cycle pulse when the RAM config is committed.
rom_stb  out  1  one-cycle pulse when the ROM config is committed.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, dominant over everything):
  - All outputs and registers are 0; FSM is in IDLE; settle counter is 0.
  - Assertion mid-cycle aborts the cycle with no commit. DIPs are re-sampled after release.
- Startup sequence:
  - The settle counter increments on each posedge while dip_valid=0.
  - On the posedge where the counter equals DIP_SETTLE_CYCLES-1: dip_q<=dip_pins and dip_valid<=1.
  - ramadrhi_oe rises one posedge after dip_valid.
  - While dip_valid=0, the FSM is held in IDLE.
- Qualification term: io_wr = !iorq_b & !wr_b & m1_b & !adr15.
- FSM states IDLE, ARMED, DONE; cnt is 3 bits:
  - IDLE: if io_wr, set cnt=1. Then commit immediately if MIN_LOW_CYCLES==1, otherwise go to ARMED.
  - ARMED: if !io_wr, return to IDLE with no commit (glitch). Otherwise increment cnt, and when cnt==MIN_LOW_CYCLES-1 commit and go to DONE.
  - DONE: wait for iorq_b=1, then go to IDLE. This guarantees exactly one commit per I/O cycle.
- Commit uses the data and adr8 values present at the commit edge. Registers and strobes update on that same edge; strobes clear on the next edge.
  - data[7:6]==2'b11, card enabled (dip_q[3:2]!=0): update RAM config and pulse ram_stb.
    - 64K mode (dip_q[3:2]==2'b10, i.e. dip[2]=0, dip[3]=1): ramblock_q={4'b1000,data[2:0]}.
    - 1MB mode (2'b11): ramblock_q={adr8,data[5:0]}. If {adr8,data[5:3]}==SHADOW_BANK, bit 3 is forced to 0.
    - 512K mode (2'b01): ramblock_q={1'b1,data[5:0]}.
    - In all modes: mode3_q=(data[2:0]==3'b011).
  - data[7:6]==2'b11, card disabled: no update, no strobe.
  - data[7:6]==2'b10: {urom_disable_q,lrom_disable_q}=data[3:2]; pulse rom_stb. This applies whether or not the card is enabled.
  - data[7:6]==2'b00 or 2'b01 (pen/colour writes): no update, no strobe.
- Simultaneous events:
  - io_wr deasserting on the would-be commit edge means no commit.
  - An I/O write arriving before dip_valid=1 is ignored entirely, even if dip_valid rises mid-cycle: the FSM remains in IDLE or DONE until iorq_b=1.

Test Plan:
- Startup: dip_pins=4'b0100 held, reset released → dip_q=4'b0100 and dip_valid=1 on the 4th posedge; ramadrhi_oe=1 one posedge later; no earlier change.
- 512K mode, OUT &7F00,&C3 with IORQ low for 3 posedges → ramblock_q=7'h43, mode3_q=1, ram_stb high exactly 1 cycle after the 2nd low posedge.
- 1MB mode, adr8=0, data=8'hFC → alias applied, ramblock_q=7'h34, mode3_q=0. Same stimulus with adr8=1 → ramblock_q=7'h7C.
- Glitch / interrupt acknowledge: iorq_b low for 1 posedge with data=8'hC1 → no change. iorq_b=0, m1_b=0, wr_b=0 for 4 posedges → no change, busy stays 0.
- ROM control: data=8'h8C → urom_disable_q=1, lrom_disable_q=1, rom_stb pulses once. IORQ held 6 posedges → still exactly one pulse. Card disabled with data=8'hC2 → ramblock_q unchanged.
- Reset mid-cycle: reset_b pulled low in ARMED → all outputs 0 immediately. After release, the pending cycle never commits and DIPs are re-sampled.

Source files
------------

// File: rtl/cpc_io_cfg_capture.sv
// Config-port capture for the 1MB RAM expansion: qualifies Z80 I/O writes to the
// Gate Array / RAM port, latches bank and ROM-disable registers, samples DIPs once.
module cpc_io_cfg_capture #(
  parameter logic [3:0] SHADOW_BANK       = 4'b0111,
  parameter int         MIN_LOW_CYCLES    = 2,
  parameter int         DIP_SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       iorq_b,
  input  logic       wr_b,
  input  logic       m1_b,
  input  logic       adr15,
  input  logic       adr8,
  input  logic [7:0] data,
  input  logic [3:0] dip_pins,
  output logic [3:0] dip_q,
  output logic       dip_valid,
  output logic       ramadrhi_oe,
  output logic [6:0] ramblock_q,
  output logic       mode3_q,
  output logic       urom_disable_q,
  output logic       lrom_disable_q,
  output logic       ram_stb,
  output logic       rom_stb,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] LAST_CNT    = 3'(MIN_LOW_CYCLES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(DIP_SETTLE_CYCLES - 1);

  logic [1:0] state, next_state;
  logic [2:0] cnt, next_cnt;
  logic [3:0] settle_cnt;
  logic       stale;
  logic       io_wr;
  logic       commit;
  logic       card_en;
  logic [6:0] bank_1mb;
  logic [6:0] new_block;

  assign io_wr   = !iorq_b && !wr_b && m1_b && !adr15;
  assign card_en = |dip_q[3:2];
  assign busy    = (state != IDLE);

  // Qualification FSM: one commit per I/O cycle, only after io_wr has held long enough.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (dip_valid && !stale && io_wr) begin
          next_cnt = 3'd1;
          if (MIN_LOW_CYCLES == 1) begin
            commit     = 1'b1;
            next_state = DONE;
          end else begin
            next_state = ARMED;
          end
        end
      end
      ARMED: begin
        if (!io_wr) begin
          next_state = IDLE;
        end else begin
          next_cnt = cnt + 3'd1;
          if (cnt == LAST_CNT) begin
            commit     = 1'b1;
            next_state = DONE;
          end
        end
      end
      DONE: begin
        if (iorq_b) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bank value per card mode; the shadow bank is aliased by clearing bit 3 in 1MB mode.
  always_comb begin
    bank_1mb = {adr8, data[5:0]};
    if ({adr8, data[5:3]} == SHADOW_BANK) bank_1mb[3] = 1'b0;
    case (dip_q[3:2])
      2'b10:   new_block = {4'b1000, data[2:0]};
      2'b11:   new_block = bank_1mb;
      2'b01:   new_block = {1'b1, data[5:0]};
      default: new_block = ramblock_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      cnt   <= 3'd0;
      stale <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      stale <= iorq_b ? 1'b0 : (stale || !dip_valid);
    end
  end

  // DIPs share pins with the RAM high address, so drive those pins only after sampling.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      settle_cnt  <= 4'd0;
      dip_q       <= 4'd0;
      dip_valid   <= 1'b0;
      ramadrhi_oe <= 1'b0;
    end else begin
      ramadrhi_oe <= dip_valid;
      if (!dip_valid) begin
        settle_cnt <= settle_cnt + 4'd1;
        if (settle_cnt == SETTLE_LAST) begin
          dip_q     <= dip_pins;
          dip_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ramblock_q     <= 7'd0;
      mode3_q        <= 1'b0;
      urom_disable_q <= 1'b0;
      lrom_disable_q <= 1'b0;
      ram_stb        <= 1'b0;
      rom_stb        <= 1'b0;
    end else begin
      ram_stb <= 1'b0;
      rom_stb <= 1'b0;
      if (commit) begin
        if (data[7:6] == 2'b11 && card_en) begin
          ramblock_q <= new_block;
          mode3_q    <= (data[2:0] == 3'b011);
          ram_stb    <= 1'b1;
        end else if (data[7:6] == 2'b10) begin
          urom_disable_q <= data[3];
          lrom_disable_q <= data[2];
          rom_stb        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpc_io_cfg_capture.sv
// Directed bench for cpc_io_cfg_capture: startup, card modes, glitch rejection,
// ROM control and mid-cycle reset.
module tb_cpc_io_cfg_capture;

  logic       clk = 1'b0;
  logic       reset_b = 1'b1;
  logic       iorq_b = 1'b1, wr_b = 1'b1, m1_b = 1'b1, adr15 = 1'b0, adr8 = 1'b0;
  logic [7:0] data = 8'h00;
  logic [3:0] dip_pins = 4'h0;
  logic [3:0] dip_q;
  logic       dip_valid, ramadrhi_oe, mode3_q, urom_disable_q, lrom_disable_q;
  logic       ram_stb, rom_stb, busy;
  logic [6:0] ramblock_q;

  int checks = 0;
  int passed = 0;
  int ram_n, rom_n, first_ram;
  logic busy_seen;

  cpc_io_cfg_capture dut (
    .clk(clk), .reset_b(reset_b), .iorq_b(iorq_b), .wr_b(wr_b), .m1_b(m1_b),
    .adr15(adr15), .adr8(adr8), .data(data), .dip_pins(dip_pins),
    .dip_q(dip_q), .dip_valid(dip_valid), .ramadrhi_oe(ramadrhi_oe),
    .ramblock_q(ramblock_q), .mode3_q(mode3_q), .urom_disable_q(urom_disable_q),
    .lrom_disable_q(lrom_disable_q), .ram_stb(ram_stb), .rom_stb(rom_stb), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset(input logic [3:0] dips);
    iorq_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
    reset_b = 1'b0;
    dip_pins = dips;
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // One Z80 OUT cycle with IORQ/WR low for 'edges' posedges, counting strobes seen.
  task automatic io_cycle(input logic a8, input logic [7:0] d, input int edges, input logic m1);
    @(negedge clk);
    iorq_b = 1'b0; wr_b = 1'b0; m1_b = m1; adr15 = 1'b0; adr8 = a8; data = d;
    ram_n = 0; rom_n = 0; first_ram = -1; busy_seen = 1'b0;
    for (int i = 1; i <= edges; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ram_stb) begin ram_n++; if (first_ram < 0) first_ram = i; end
      if (rom_stb) rom_n++;
      busy_seen |= busy;
    end
    iorq_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ram_stb) ram_n++;
      if (rom_stb) rom_n++;
    end
  endtask

  task automatic test_reset();
    dip_pins = 4'b0100;
    #1 reset_b = 1'b0;
    #2;
    checks++; if ({dip_valid, ramadrhi_oe, ramblock_q, ram_stb, rom_stb, busy} !== 12'h000)
      $display("FAIL reset_outputs: got %h want 000", {dip_valid, ramadrhi_oe, ramblock_q, ram_stb, rom_stb, busy}); else passed++;
    @(negedge clk);
    reset_b = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (dip_valid !== (k >= 4))
        $display("FAIL startup_valid edge %0d: got %b want %b", k, dip_valid, (k >= 4)); else passed++;
      checks++; if (ramadrhi_oe !== (k >= 5))
        $display("FAIL startup_oe edge %0d: got %b want %b", k, ramadrhi_oe, (k >= 5)); else passed++;
      checks++; if (dip_q !== ((k >= 4) ? 4'b0100 : 4'b0000))
        $display("FAIL startup_dipq edge %0d: got %b", k, dip_q); else passed++;
    end
  endtask

  task automatic test_512k();
    io_cycle(1'b0, 8'hC3, 3, 1'b1);
    checks++; if (ramblock_q !== 7'h43) $display("FAIL 512k_block: got %h want 43", ramblock_q); else passed++;
    checks++; if (mode3_q !== 1'b1) $display("FAIL 512k_mode3: got %b want 1", mode3_q); else passed++;
    checks++; if (ram_n !== 1) $display("FAIL 512k_stb_count: got %0d want 1", ram_n); else passed++;
    checks++; if (first_ram !== 2) $display("FAIL 512k_stb_edge: got %0d want 2", first_ram); else passed++;
    checks++; if (rom_n !== 0) $display("FAIL 512k_rom_stb: got %0d want 0", rom_n); else passed++;
  endtask

  task automatic test_glitch();
    io_cycle(1'b0, 8'hC1, 1, 1'b1);
    checks++; if (ramblock_q !== 7'h43) $display("FAIL glitch_block: got %h want 43", ramblock_q); else passed++;
    checks++; if (ram_n !== 0) $display("FAIL glitch_stb: got %0d want 0", ram_n); else passed++;
    io_cycle(1'b0, 8'hC1, 4, 1'b0);
    checks++; if (busy_seen !== 1'b0) $display("FAIL intack_busy: got %b want 0", busy_seen); else passed++;
    checks++; if (ram_n !== 0) $display("FAIL intack_stb: got %0d want 0", ram_n); else passed++;
    checks++; if (mode3_q !== 1'b1) $display("FAIL intack_mode3: got %b want 1", mode3_q); else passed++;
    io_cycle(1'b0, 8'h43, 3, 1'b1);
    checks++; if ((ram_n + rom_n) !== 0) $display("FAIL pen_write_stb: got %0d want 0", ram_n + rom_n); else passed++;
    checks++; if (ramblock_q !== 7'h43) $display("FAIL pen_write_block: got %h want 43", ramblock_q); else passed++;
  endtask

  task automatic test_rom();
    io_cycle(1'b0, 8'h8C, 2, 1'b1);
    checks++; if ({urom_disable_q, lrom_disable_q} !== 2'b11)
      $display("FAIL rom_8c: got %b want 11", {urom_disable_q, lrom_disable_q}); else passed++;
    checks++; if (rom_n !== 1) $display("FAIL rom_8c_stb: got %0d want 1", rom_n); else passed++;
    checks++; if (ram_n !== 0) $display("FAIL rom_8c_ram_stb: got %0d want 0", ram_n); else passed++;
    io_cycle(1'b0, 8'h84, 6, 1'b1);
    checks++; if (rom_n !== 1) $display("FAIL rom_long_stb: got %0d want 1", rom_n); else passed++;
    checks++; if ({urom_disable_q, lrom_disable_q} !== 2'b01)
      $display("FAIL rom_84: got %b want 01", {urom_disable_q, lrom_disable_q}); else passed++;
    checks++; if (ramblock_q !== 7'h43) $display("FAIL rom_block_kept: got %h want 43", ramblock_q); else passed++;
  endtask

  task automatic test_64k();
    apply_reset(4'b1000);
    io_cycle(1'b0, 8'hC5, 2, 1'b1);
    checks++; if (ramblock_q !== 7'h45) $display("FAIL 64k_block: got %h want 45", ramblock_q); else passed++;
    checks++; if (mode3_q !== 1'b0) $display("FAIL 64k_mode3: got %b want 0", mode3_q); else passed++;
  endtask

  task automatic test_1mb();
    apply_reset(4'b1100);
    io_cycle(1'b0, 8'hFC, 2, 1'b1);
    checks++; if (ramblock_q !== 7'h34) $display("FAIL 1mb_alias: got %h want 34", ramblock_q); else passed++;
    checks++; if (mode3_q !== 1'b0) $display("FAIL 1mb_mode3: got %b want 0", mode3_q); else passed++;
    io_cycle(1'b1, 8'hFC, 2, 1'b1);
    checks++; if (ramblock_q !== 7'h7C) $display("FAIL 1mb_adr8: got %h want 7c", ramblock_q); else passed++;
    io_cycle(1'b0, 8'hC3, 2, 1'b1);
    checks++; if (ramblock_q !== 7'h03) $display("FAIL 1mb_plain: got %h want 03", ramblock_q); else passed++;
    checks++; if (mode3_q !== 1'b1) $display("FAIL 1mb_mode3_set: got %b want 1", mode3_q); else passed++;
  endtask

  task automatic test_card_disabled();
    apply_reset(4'b0000);
    io_cycle(1'b0, 8'hC2, 2, 1'b1);
    checks++; if (ram_n !== 0) $display("FAIL disabled_stb: got %0d want 0", ram_n); else passed++;
    checks++; if (ramblock_q !== 7'h00) $display("FAIL disabled_block: got %h want 00", ramblock_q); else passed++;
    io_cycle(1'b0, 8'h88, 2, 1'b1);
    checks++; if ({urom_disable_q, lrom_disable_q, rom_n[1:0]} !== 4'b1001)
      $display("FAIL disabled_rom: got %b want 1001", {urom_disable_q, lrom_disable_q, rom_n[1:0]}); else passed++;
  endtask

  task automatic test_reset_mid_cycle();
    apply_reset(4'b0100);
    io_cycle(1'b0, 8'hC3, 2, 1'b1);
    checks++; if (ramblock_q !== 7'h43) $display("FAIL mid_preload: got %h want 43", ramblock_q); else passed++;
    @(negedge clk);
    iorq_b = 1'b0; wr_b = 1'b0; m1_b = 1'b1; adr8 = 1'b1; data = 8'hFC;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL mid_armed: got %b want 1", busy); else passed++;
    #2 reset_b = 1'b0;
    dip_pins = 4'b1100;
    #1;
    checks++; if ({ramblock_q, mode3_q, dip_valid, ramadrhi_oe, busy, dip_q} !== 15'h0)
      $display("FAIL mid_async_clear: got %h want 0", {ramblock_q, mode3_q, dip_valid, ramadrhi_oe, busy, dip_q}); else passed++;
    @(negedge clk);
    reset_b = 1'b1;
    ram_n = 0; busy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ram_stb) ram_n++;
      busy_seen |= busy;
    end
    checks++; if (ram_n !== 0) $display("FAIL mid_no_commit: got %0d want 0", ram_n); else passed++;
    checks++; if (busy_seen !== 1'b0) $display("FAIL mid_stale_busy: got %b want 0", busy_seen); else passed++;
    checks++; if (ramblock_q !== 7'h00) $display("FAIL mid_block: got %h want 00", ramblock_q); else passed++;
    checks++; if (dip_q !== 4'b1100) $display("FAIL mid_resample: got %b want 1100", dip_q); else passed++;
    iorq_b = 1'b1; wr_b = 1'b1;
    io_cycle(1'b1, 8'hFC, 2, 1'b1);
    checks++; if (ramblock_q !== 7'h7C) $display("FAIL mid_after: got %h want 7c", ramblock_q); else passed++;
  endtask

  initial begin
    test_reset();
    test_512k();
    test_glitch();
    test_rom();
    test_64k();
    test_1mb();
    test_card_disabled();
    test_reset_mid_cycle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
